// File: rtl/serial_adder.sv
// Bit-serial adder with valid/ready handshakes on both sides.
// An accepted operand set is added one bit per clock, LSB first.
// The result is presented in DONE until downstream takes it.
// The sum register and the carry register drive s and c_out directly,
// so the last delivered result stays visible while idle.
// WIDTH is meant to lie in 2..16.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;

  // One full-adder slice operating on the current LSBs and the running carry
  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  assign s     = sum_reg;
  assign c_out = carry;
  assign busy  = (state != IDLE);

  // Handshake FSM and the bit-serial datapath it sequences
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= c_in;
            cnt      <= '0;
            sum_reg  <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry   <= carry_next;
          sum_reg <= {sum_bit, sum_reg[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=4.
// Expected sums are pushed to a queue when operands are driven.
// They are popped and compared when the adder presents a result.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             c_in = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic             c_out;
  logic             busy;
  logic [WIDTH-1:0] s;

  logic [WIDTH:0]   exp_q[$];
  int               pass_cnt = 0;
  int               total_cnt = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c_in(c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s(s),
    .c_out(c_out),
    .busy(busy)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  // Waits (bounded) for the driven operands to be accepted; returns just after the capturing edge
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Waits (bounded) for out_valid; returns on the falling edge where it is seen
  task automatic wait_out(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Outputs while reset is held, and in_ready coming up after release
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy);
    else pass_cnt++;
    total_cnt++;
    if ({c_out, s} !== '0) $display("[TB] FAIL reset_sum got=%h want=0", {c_out, s});
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL post_reset_busy got=%b want=0", busy);
    else pass_cnt++;
  endtask

  // 3+5+0: latency, busy window, result, and result held in IDLE
  task automatic test_basic();
    bit ok;
    logic [WIDTH:0] exp;
    total_cnt++;
    if ({c_out, s} !== '0) $display("[TB] FAIL basic_initial_sum got=%h want=0", {c_out, s});
    else pass_cnt++;
    out_ready = 1'b1;
    a = 4'd3; b = 4'd5; c_in = 1'b0; in_valid = 1'b1;
    exp_q.push_back(ref_sum(a, b, c_in));
    wait_accept(ok);
    total_cnt++;
    if (!ok) $display("[TB] FAIL basic_accept got=timeout want=accept");
    else pass_cnt++;
    for (int k = 0; k <= WIDTH; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid = 1'b0; a = 4'd15; b = 4'd15; c_in = 1'b1;
      end
      total_cnt++;
      if (busy !== 1'b1) $display("[TB] FAIL basic_busy_%0d got=%b want=1", k, busy);
      else pass_cnt++;
      total_cnt++;
      if (out_valid !== (k == WIDTH)) $display("[TB] FAIL basic_out_valid_%0d got=%b want=%b", k, out_valid, (k == WIDTH));
      else pass_cnt++;
      if (k == WIDTH) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++;
        if ({c_out, s} !== exp) $display("[TB] FAIL basic_sum got=%h want=%h", {c_out, s}, exp);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL basic_idle got=busy%b/ov%b/ir%b want=busy0/ov0/ir1", busy, out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({c_out, s} !== 5'd8) $display("[TB] FAIL basic_hold got=%h want=08", {c_out, s});
    else pass_cnt++;
  endtask

  // Carry-out boundary cases
  task automatic test_overflow();
    logic [WIDTH-1:0] ta[2] = '{4'd15, 4'd15};
    logic [WIDTH-1:0] tb[2] = '{4'd1, 4'd15};
    logic             tc[2] = '{1'b0, 1'b1};
    logic [WIDTH:0]   exp;
    bit ok;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      a = ta[t]; b = tb[t]; c_in = tc[t]; in_valid = 1'b1;
      exp_q.push_back(ref_sum(a, b, c_in));
      wait_accept(ok);
      in_valid = 1'b0;
      wait_out(20, ok);
      total_cnt++;
      if (!ok) $display("[TB] FAIL overflow_out_%0d got=timeout want=out_valid", t);
      else pass_cnt++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total_cnt++;
      if ({c_out, s} !== exp) $display("[TB] FAIL overflow_sum_%0d got=%h want=%h", t, {c_out, s}, exp);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  // Downstream stalls in DONE while upstream keeps offering new operands
  task automatic test_backpressure();
    logic [WIDTH:0] exp;
    bit ok;
    out_ready = 1'b0;
    a = 4'd6; b = 4'd7; c_in = 1'b1; in_valid = 1'b1;
    exp_q.push_back(ref_sum(a, b, c_in));
    wait_accept(ok);
    a = 4'd1; b = 4'd2; c_in = 1'b0;
    wait_out(20, ok);
    total_cnt++;
    if (!ok) $display("[TB] FAIL stall_out got=timeout want=out_valid");
    else pass_cnt++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int k = 0; k < 10; k++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("[TB] FAIL stall_hs_%0d got=ov%b/ir%b want=ov1/ir0", k, out_valid, in_ready);
      else pass_cnt++;
      total_cnt++;
      if ({c_out, s} !== exp) $display("[TB] FAIL stall_sum_%0d got=%h want=%h", k, {c_out, s}, exp);
      else pass_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL stall_release got=ov%b/busy%b/ir%b want=ov0/busy0/ir1", out_valid, busy, in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({c_out, s} !== exp) $display("[TB] FAIL stall_after_sum got=%h want=%h", {c_out, s}, exp);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // Reset in the middle of RUN abandons the operation; the next one is clean
  task automatic test_reset_mid_run();
    logic [WIDTH:0] exp;
    bit ok;
    bit seen;
    out_ready = 1'b1;
    a = 4'd9; b = 4'd9; c_in = 1'b0; in_valid = 1'b1;
    exp_q.push_back(ref_sum(a, b, c_in));
    wait_accept(ok);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total_cnt++;
    if ({busy, out_valid, in_ready, c_out, s} !== '0)
      $display("[TB] FAIL midreset_outputs got=%b want=0", {busy, out_valid, in_ready, c_out, s});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("[TB] FAIL midreset_no_output got=out_valid want=none");
    else pass_cnt++;
    a = 4'd7; b = 4'd9; c_in = 1'b0; in_valid = 1'b1;
    exp_q.push_back(ref_sum(a, b, c_in));
    wait_accept(ok);
    in_valid = 1'b0;
    wait_out(20, ok);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    total_cnt++;
    if (!ok || {c_out, s} !== exp) $display("[TB] FAIL midreset_next_sum got=%h want=%h", {c_out, s}, exp);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // Both sides always ready: fixed accept period and random operands
  task automatic test_back_to_back();
    int accepts = 0;
    int outs = 0;
    int last_acc = -1;
    logic [WIDTH:0] exp;
    out_ready = 1'b1;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); in_valid = 1'b1;
    for (int cyc = 0; cyc < 1400 && outs < 200; cyc++) begin
      if (out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++;
        if ({c_out, s} !== exp) $display("[TB] FAIL b2b_sum_%0d got=%h want=%h", outs, {c_out, s}, exp);
        else pass_cnt++;
        outs++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(ref_sum(a, b, c_in));
        if (last_acc >= 0) begin
          total_cnt++;
          if (cyc - last_acc != WIDTH + 2)
            $display("[TB] FAIL b2b_period_%0d got=%0d want=%0d", accepts, cyc - last_acc, WIDTH + 2);
          else pass_cnt++;
        end
        last_acc = cyc;
        accepts++;
      end else begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
        if (accepts >= 200) in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total_cnt++;
    if (outs != 200) $display("[TB] FAIL b2b_count got=%0d want=200", outs);
    else pass_cnt++;
  endtask

  // Every (a, b, c_in) combination
  task automatic test_exhaustive();
    int idx = 0;
    int outs = 0;
    logic [8:0] iv;
    logic [WIDTH:0] exp;
    out_ready = 1'b1;
    iv = 9'(idx);
    a = iv[3:0]; b = iv[7:4]; c_in = iv[8]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 3300 && outs < 512; cyc++) begin
      if (out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++;
        if ({c_out, s} !== exp) $display("[TB] FAIL sweep_sum_%0d got=%h want=%h", outs, {c_out, s}, exp);
        else pass_cnt++;
        outs++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(ref_sum(a, b, c_in));
        idx++;
      end else if (idx < 512) begin
        iv = 9'(idx);
        a = iv[3:0]; b = iv[7:4]; c_in = iv[8];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total_cnt++;
    if (outs != 512) $display("[TB] FAIL sweep_count got=%0d want=512", outs);
    else pass_cnt++;
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; legal range 2..16.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream operand set valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 c_in  input  1  carry-in.
REQ-009 out_valid  output  1  result valid to downstream.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 s  output  WIDTH  sum bits.
REQ-012 c_out  output  1  carry-out of MSB.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with no other reachable states.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready at an edge, capture a, b into shift registers and c_in into the carry register, clear the bit counter and the sum register, and go to RUN.
REQ-016 RUN: each edge, sum bit = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry); a_sh, b_sh shift right; sum bit shifts into the sum register from the MSB side; counter increments.
REQ-017 RUN SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1, go to DONE.
REQ-018 Latency: if the operand set is accepted at edge t0, then out_valid SHALL be high from edge t0+WIDTH.
REQ-019 DONE: out_valid=1; s = sum register; c_out = final carry; s and c_out stable until the handshake.
REQ-020 DONE with out_ready=1 at an edge: go to IDLE.
REQ-021 DONE with out_ready=0: hold DONE indefinitely.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid, a, b and c_in are ignored whenever in_ready=0.
REQ-023 There is no same-cycle turnaround: the DONE-to-IDLE edge never accepts new operands, so the minimum accept-to-accept period is WIDTH+2 cycles.
REQ-024 out_ready SHALL be ignored when out_valid=0.
REQ-025 {c_out,s} SHALL equal (a+b+c_in) mod 2^(WIDTH+1) for the captured operands.
REQ-026 In IDLE, s and c_out SHALL hold the last delivered result (zero after reset).
REQ-027 Operand changes after capture SHALL NOT affect the result in progress.

Reset
REQ-028 When Resetn is low: state=IDLE, and s, c_out, out_valid, busy, shift registers, carry and counter are all 0, asynchronously and without waiting for a Clock edge.
REQ-029 in_ready SHALL be 0 while Resetn is low and SHALL be 1 from the first Clock cycle after Resetn deasserts.
REQ-030 Reset asserted in RUN or DONE abandons the operation and produces no output handshake.
REQ-031 Resetn deassertion is synchronous to Clock at the system level; the block needs no internal synchronizer.

Verification (WIDTH=4)
REQ-032 a=3, b=5, c_in=0 accepted at t0 -> out_valid at t0+4, s=8, c_out=0, busy high t0..t0+4.
REQ-033 a=15, b=1, c_in=0 -> s=0, c_out=1; then a=15, b=15, c_in=1 -> s=15, c_out=1.
REQ-034 out_ready held 0 for 10 cycles in DONE, while in_valid=1 with a=1 -> s and c_out stable, in_ready=0, no capture; out_ready=1 -> IDLE next edge.
REQ-035 Resetn pulsed low mid-RUN (second bit) with a=9, b=9 -> all outputs 0 immediately, no out_valid; then 7+9+0 -> s=0, c_out=1.
REQ-036 in_valid and out_ready held 1 with random operands for 200 transactions -> accept period exactly 6 cycles, every {c_out,s} matches the reference sum.
REQ-037 Exhaustive sweep of all 512 (a, b, c_in) combinations -> every result matches (a+b+c_in) mod 32.
